x7seg_mux: RTL and testbench

X7SEG_MUX -- requirements
Module: x7seg_mux

---
 rtl/x7seg_mux.sv | 128 ++++++++++++
 tb/tb_x7seg_mux.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/x7seg_mux.sv
// Multiplexed 7-segment driver: frame-synchronous shadow load, leading-zero
// blanking, per-digit enable and PWM brightness on the anodes.
module x7seg_mux #(
  parameter int NDIG       = 8,
  parameter int TICK_CNT   = 100000,
  parameter int BRIGHT_W   = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [4*NDIG-1:0]     x,
  input  logic [NDIG-1:0]       dp,
  input  logic [NDIG-1:0]       en,
  input  logic                  load,
  input  logic                  lzb,
  input  logic [BRIGHT_W-1:0]   bright,
  output logic [NDIG-1:0]       an,
  output logic [6:0]            a_to_g,
  output logic                  dp_out,
  output logic                  frame
);

  localparam int PW = $clog2(TICK_CNT);
  localparam int IW = $clog2(NDIG);

  logic [PW-1:0]       pre_cnt;
  logic [IW-1:0]       idx;
  logic                pending;
  logic [4*NDIG-1:0]   sh_x;
  logic [NDIG-1:0]     sh_dp;
  logic [NDIG-1:0]     sh_en;
  logic [NDIG-1:0]     an_r;
  logic [6:0]          seg_r;
  logic                dp_r;
  logic                frame_r;

  logic                tick;
  logic                wrap;
  logic [NDIG-1:0]     blank;
  logic                zero_above;
  logic [3:0]          cur_nib;
  logic                on;
  logic [NDIG-1:0]     an_nx;
  logic [6:0]          seg_nx;
  logic                dp_nx;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'b1111110;
      4'h1: seg7 = 7'b0110000;
      4'h2: seg7 = 7'b1101101;
      4'h3: seg7 = 7'b1111001;
      4'h4: seg7 = 7'b0110011;
      4'h5: seg7 = 7'b1011011;
      4'h6: seg7 = 7'b1011111;
      4'h7: seg7 = 7'b1110000;
      4'h8: seg7 = 7'b1111111;
      4'h9: seg7 = 7'b1111011;
      4'hA: seg7 = 7'b1110111;
      4'hB: seg7 = 7'b0011111;
      4'hC: seg7 = 7'b1001110;
      4'hD: seg7 = 7'b0111101;
      4'hE: seg7 = 7'b1001111;
      default: seg7 = 7'b1000111;
    endcase
  endfunction

  assign tick = (pre_cnt == PW'(TICK_CNT - 1));
  assign wrap = tick && (idx == IW'(NDIG - 1));

  // A digit blanks only if it and every digit above it are zero; digit 0 never.
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int i = NDIG - 1; i > 0; i--) begin
      zero_above = zero_above && (sh_x[4*i +: 4] == 4'h0);
      blank[i]   = lzb && zero_above;
    end
  end

  always_comb begin
    cur_nib = sh_x[4*idx +: 4];
    on      = sh_en[idx] && (pre_cnt[BRIGHT_W-1:0] <= bright);
    an_nx   = '0;
    if (on) an_nx[idx] = 1'b1;
    seg_nx  = (sh_en[idx] && !blank[idx]) ? seg7(cur_nib) : 7'b0;
    dp_nx   = sh_en[idx] & sh_dp[idx];
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      pre_cnt <= '0;
      idx     <= '0;
      pending <= 1'b0;
      sh_x    <= '0;
      sh_dp   <= '0;
      sh_en   <= '1;
      frame_r <= 1'b0;
      an_r    <= '0;
      seg_r   <= '0;
      dp_r    <= 1'b0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (tick) idx <= (idx == IW'(NDIG - 1)) ? '0 : idx + 1'b1;
      frame_r <= wrap;
      // Shadows only move at the frame boundary so a frame never tears.
      if (wrap) begin
        if (load || pending) begin
          sh_x  <= x;
          sh_dp <= dp;
          sh_en <= en;
        end
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
      an_r  <= an_nx;
      seg_r <= seg_nx;
      dp_r  <= dp_nx;
    end
  end

  assign an     = (ACTIVE_LOW != 0) ? ~an_r  : an_r;
  assign a_to_g = (ACTIVE_LOW != 0) ? ~seg_r : seg_r;
  assign dp_out = (ACTIVE_LOW != 0) ? ~dp_r  : dp_r;
  assign frame  = frame_r;

endmodule

// File: tb/tb_x7seg_mux.sv
// Directed bench for x7seg_mux: reset, scan, tear-free load, blanking,
// dimming/enable, reset discarding a pending load, and an active-low build.
module tb_x7seg_mux;
  localparam int NDIG = 4;
  localparam int TICK = 4;
  localparam int BW   = 2;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [15:0] x = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  en = 4'hF;
  logic        load = 1'b0;
  logic        lzb = 1'b0;
  logic [1:0]  bright = 2'd3;

  logic [3:0]  an, an_l;
  logic [6:0]  seg, seg_l;
  logic        dpo, dpo_l, frame, frame_l;

  int n_chk  = 0;
  int n_fail = 0;

  logic [6:0] seg_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  x7seg_mux #(.NDIG(NDIG), .TICK_CNT(TICK), .BRIGHT_W(BW), .ACTIVE_LOW(0)) dut (
    .clk(clk), .clr(clr), .x(x), .dp(dp), .en(en), .load(load), .lzb(lzb),
    .bright(bright), .an(an), .a_to_g(seg), .dp_out(dpo), .frame(frame));

  x7seg_mux #(.NDIG(NDIG), .TICK_CNT(TICK), .BRIGHT_W(BW), .ACTIVE_LOW(1)) dut_l (
    .clk(clk), .clr(clr), .x(x), .dp(dp), .en(en), .load(load), .lzb(lzb),
    .bright(bright), .an(an_l), .a_to_g(seg_l), .dp_out(dpo_l), .frame(frame_l));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frame;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      step;
      if (frame === 1'b1) seen = 1'b1;
    end
    chk("frame_wait", {31'd0, seen}, 32'd1);
  endtask

  // Checks one full 16-cycle frame; optionally issues a load at cycle load_at.
  task automatic frame_chk(input string tag, input logic [15:0] xv, input logic [3:0] dpv,
                           input logic [3:0] env, input logic lz, input logic [1:0] br,
                           input int load_at, input logic [15:0] nx,
                           input logic [3:0] ndp, input logic [3:0] nen);
    int d, p;
    logic [3:0] nib, ea;
    logic [6:0] es;
    logic ed, bl;
    for (int c = 0; c < 16; c++) begin
      d = c / 4;
      p = c % 4;
      step;
      nib = xv[4*d +: 4];
      bl  = lz && (d > 0) && ((xv >> (4*d)) == 16'd0);
      ea  = (env[d] && (p <= int'(br))) ? (4'b0001 << d) : 4'b0000;
      es  = !env[d] ? 7'b0 : (bl ? 7'b0 : seg_tab[nib]);
      ed  = env[d] & dpv[d];
      chk({tag, "_an"},    {28'd0, an},    {28'd0, ea});
      chk({tag, "_seg"},   {25'd0, seg},   {25'd0, es});
      chk({tag, "_dp"},    {31'd0, dpo},   {31'd0, ed});
      chk({tag, "_frame"}, {31'd0, frame}, {31'd0, (c == 15)});
      chk({tag, "_an_l"},  {28'd0, an_l},  {28'd0, ~ea});
      chk({tag, "_seg_l"}, {25'd0, seg_l}, {25'd0, ~es});
      if (c == load_at) begin
        x = nx; dp = ndp; en = nen; load = 1'b1;
      end else if (c == load_at + 1) begin
        load = 1'b0;
      end
    end
  endtask

  initial begin
    clr = 1'b1;
    step;
    step;
    chk("rst_an",     {28'd0, an},      32'h0);
    chk("rst_seg",    {25'd0, seg},     32'h0);
    chk("rst_dp",     {31'd0, dpo},     32'h0);
    chk("rst_frame",  {31'd0, frame},   32'h0);
    chk("rst_an_l",   {28'd0, an_l},    32'hF);
    chk("rst_seg_l",  {25'd0, seg_l},   32'h7F);
    chk("rst_dp_l",   {31'd0, dpo_l},   32'h1);

    clr = 1'b0;
    step;
    chk("rel_an",  {28'd0, an},  32'h1);
    chk("rel_seg", {25'd0, seg}, {25'd0, 7'b1111110});

    x = 16'h1234; load = 1'b1;
    step;
    load = 1'b0;
    wait_frame;
    frame_chk("scan", 16'h1234, 4'h0, 4'hF, 1'b0, 2'd3, -1, 16'h0, 4'h0, 4'h0);
    frame_chk("tear", 16'h1234, 4'h0, 4'hF, 1'b0, 2'd3, 4, 16'hABCD, 4'h0, 4'hF);
    frame_chk("abcd", 16'hABCD, 4'h0, 4'hF, 1'b0, 2'd3, 14, 16'h0050, 4'b0110, 4'hF);
    lzb = 1'b1;
    frame_chk("blank", 16'h0050, 4'b0110, 4'hF, 1'b1, 2'd3, 14, 16'hF0E9, 4'b0001, 4'b1011);
    lzb = 1'b0; bright = 2'd0;
    frame_chk("dim", 16'hF0E9, 4'b0001, 4'b1011, 1'b0, 2'd0, -1, 16'h0, 4'h0, 4'h0);

    bright = 2'd3;
    for (int i = 0; i < 5; i++) step;
    x = 16'h5555; load = 1'b1;
    step;
    load = 1'b0;
    step;
    clr = 1'b1; load = 1'b1;
    step;
    chk("clr_an", {28'd0, an}, 32'h0);
    load = 1'b0;
    step;
    clr = 1'b0;
    step;
    chk("clr_rel_an",  {28'd0, an},  32'h1);
    chk("clr_rel_seg", {25'd0, seg}, {25'd0, 7'b1111110});
    wait_frame;
    frame_chk("clr", 16'h0000, 4'h0, 4'hF, 1'b0, 2'd3, -1, 16'h0, 4'h0, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
